draw_game_bg_scroll: RTL and testbench



---
 rtl/draw_game_bg_scroll_if.sv | 13 +
 rtl/draw_game_bg_scroll.sv | 99 +++++++++
 tb/tb_draw_game_bg_scroll.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_game_bg_scroll_if.sv
// VGA timing bundle passed between draw-chain stages; rgb rides along with the timing.
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_game_bg_scroll.sv
// Game background stage: patterned fill with per-frame scrolling and a timed flash,
// re-registering the VGA timing with one clock of latency.
module draw_game_bg_scroll #(
  parameter int unsigned TILE_LOG2    = 5,
  parameter logic [11:0] COLOR_A      = 12'h223,
  parameter logic [11:0] COLOR_B      = 12'h334,
  parameter logic [11:0] FLASH_COLOR  = 12'hF00,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter int unsigned SCROLL_STEP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       scroll_en,
  input  logic       flash_req,
  output logic       flash_busy,
  vga_if.in          in,
  vga_if.out         out
);

  logic [10:0] offset;
  logic [1:0]  mode_q;
  logic [7:0]  flash_cnt;
  logic [7:0]  flash_cnt_next;
  logic        vblnk_prev;
  logic        frame_start;
  logic [10:0] h_sum;
  logic [10:0] v_sum;
  logic        pat_sel;
  logic [11:0] rgb_next;

  assign frame_start = in.vblnk && !vblnk_prev;
  assign h_sum       = in.hcount + offset;
  assign v_sum       = in.vcount + offset;

  // A request reloads the counter even on a frame start, so the reload wins over the decrement.
  always_comb begin
    flash_cnt_next = flash_cnt;
    if (flash_req) begin
      flash_cnt_next = 8'(FLASH_FRAMES);
    end else if (frame_start && (flash_cnt != 8'd0)) begin
      flash_cnt_next = flash_cnt - 8'd1;
    end
  end

  always_comb begin
    pat_sel  = 1'b0;
    rgb_next = 12'h000;
    case (mode_q)
      2'd1:    pat_sel = v_sum[TILE_LOG2];
      2'd2:    pat_sel = h_sum[TILE_LOG2] ^ in.vcount[TILE_LOG2];
      2'd3:    pat_sel = h_sum[TILE_LOG2];
      default: pat_sel = 1'b0;
    endcase
    if (in.hblnk || in.vblnk) begin
      rgb_next = 12'h000;
    end else if (flash_cnt != 8'd0) begin
      rgb_next = FLASH_COLOR;
    end else begin
      rgb_next = pat_sel ? COLOR_B : COLOR_A;
    end
  end

  // vblnk_prev powers up high so leaving reset inside vblank is not seen as a frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset     <= '0;
      mode_q     <= '0;
      flash_cnt  <= '0;
      vblnk_prev <= 1'b1;
      flash_busy <= 1'b0;
      out.vcount <= '0;
      out.hcount <= '0;
      out.vsync  <= 1'b0;
      out.hsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      vblnk_prev <= in.vblnk;
      flash_cnt  <= flash_cnt_next;
      flash_busy <= (flash_cnt_next != 8'd0);
      if (frame_start) begin
        mode_q <= mode;
        if (scroll_en) begin
          offset <= offset + 11'(SCROLL_STEP);
        end
      end
      out.vcount <= in.vcount;
      out.hcount <= in.hcount;
      out.vsync  <= in.vsync;
      out.hsync  <= in.hsync;
      out.vblnk  <= in.vblnk;
      out.hblnk  <= in.hblnk;
      out.rgb    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_draw_game_bg_scroll.sv
// Self-checking bench for draw_game_bg_scroll: a frame-level model checked every cycle,
// plus directed pixels with hand-computed colours. Uses a reduced 80x44 raster to stay short.
module tb_draw_game_bg_scroll;

  localparam int          TILE_LOG2    = 5;
  localparam logic [11:0] COLOR_A      = 12'h223;
  localparam logic [11:0] COLOR_B      = 12'h334;
  localparam logic [11:0] FLASH_COLOR  = 12'hF00;
  localparam int          FLASH_FRAMES = 8;
  localparam int          SCROLL_STEP  = 1;

  localparam int H_ACT = 64;
  localparam int H_TOT = 80;
  localparam int V_ACT = 40;
  localparam int V_TOT = 44;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       scroll_en;
  logic       flash_req;
  logic       flash_busy;

  vga_if vin ();
  vga_if vout ();

  draw_game_bg_scroll #(
    .TILE_LOG2   (TILE_LOG2),
    .COLOR_A     (COLOR_A),
    .COLOR_B     (COLOR_B),
    .FLASH_COLOR (FLASH_COLOR),
    .FLASH_FRAMES(FLASH_FRAMES),
    .SCROLL_STEP (SCROLL_STEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .scroll_en (scroll_en),
    .flash_req (flash_req),
    .flash_busy(flash_busy),
    .in        (vin),
    .out       (vout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model state: frame-level quantities of the background generator.
  int          m_offset;
  int          m_mode;
  int          m_flash;
  bit          m_vprev;
  bit          model_valid = 1'b0;
  logic [25:0] exp_timing;
  logic [11:0] exp_rgb;
  logic        exp_busy;
  int          t_offset;
  int          t_mode;
  int          t_flash;
  logic [11:0] t_rgb;

  function automatic logic [11:0] pattern_colour(input int h, input int v, input int off, input int md);
    int tile;
    int hs;
    int vs;
    int sel;
    tile = 1 << TILE_LOG2;
    hs   = (h + off) % 2048;
    vs   = (v + off) % 2048;
    case (md)
      1:       sel = (vs / tile) % 2;
      2:       sel = ((hs / tile) + (v / tile)) % 2;
      3:       sel = (hs / tile) % 2;
      default: sel = 0;
    endcase
    return (sel == 1) ? COLOR_B : COLOR_A;
  endfunction

  // The pixel colour uses the state as it was before this cycle's frame events and requests.
  always @(posedge clk) begin
    if (rst) begin
      m_offset    <= 0;
      m_mode      <= 0;
      m_flash     <= 0;
      m_vprev     <= 1'b1;
      exp_timing  <= '0;
      exp_rgb     <= '0;
      exp_busy    <= 1'b0;
      model_valid <= 1'b1;
    end else begin
      t_offset = m_offset;
      t_mode   = m_mode;
      t_flash  = m_flash;
      if (vin.hblnk || vin.vblnk)  t_rgb = 12'h000;
      else if (m_flash > 0)        t_rgb = FLASH_COLOR;
      else                         t_rgb = pattern_colour(int'(vin.hcount), int'(vin.vcount), m_offset, m_mode);
      if (vin.vblnk && !m_vprev) begin
        t_mode = int'(mode);
        if (scroll_en) t_offset = (t_offset + SCROLL_STEP) % 2048;
        if (t_flash > 0) t_flash = t_flash - 1;
      end
      if (flash_req) t_flash = FLASH_FRAMES;
      m_offset   <= t_offset;
      m_mode     <= t_mode;
      m_flash    <= t_flash;
      m_vprev    <= vin.vblnk;
      exp_timing <= {vin.vcount, vin.hcount, vin.vsync, vin.hsync, vin.vblnk, vin.hblnk};
      exp_rgb    <= t_rgb;
      exp_busy   <= (t_flash != 0);
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("timing", 32'({vout.vcount, vout.hcount, vout.vsync, vout.hsync, vout.vblnk, vout.hblnk}),
                  32'(exp_timing));
      checkOutput("rgb", 32'(vout.rgb), 32'(exp_rgb));
      checkOutput("busy", 32'(flash_busy), 32'(exp_busy));
    end
  end

  task automatic setTiming(input int h, input int v);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = (h >= H_ACT);
    vin.vblnk  = (v >= V_ACT);
    vin.hsync  = (h >= 66) && (h < 72);
    vin.vsync  = (v == 41) || (v == 42);
    vin.rgb    = 12'($urandom);
  endtask

  task automatic applyStimulus(input int h, input int v, input bit req);
    setTiming(h, v);
    flash_req = req;
    @(negedge clk);
  endtask

  task automatic checkPixel(input string name, input int h, input int v, input logic [11:0] expected);
    applyStimulus(h, v, 1'b0);
    checkOutput(name, 32'(vout.rgb), 32'(expected));
  endtask

  // Leaves vblank briefly, then re-enters it: exactly one frame start, no visible pixels.
  task automatic quickFs();
    applyStimulus(H_ACT, 0, 1'b0);
    applyStimulus(0, V_ACT, 1'b0);
  endtask

  task automatic fullFrame();
    for (int v = 0; v < V_TOT; v++)
      for (int h = 0; h < H_TOT; h++)
        applyStimulus(h, v, 1'b0);
  endtask

  task automatic flashCountdown(input string tag);
    for (int k = 1; k <= FLASH_FRAMES; k++) begin
      quickFs();
      checkPixel($sformatf("%s_fs%0d_rgb", tag, k), 3, 3, (k < FLASH_FRAMES) ? FLASH_COLOR : COLOR_A);
      checkOutput($sformatf("%s_fs%0d_busy", tag, k), 32'(flash_busy), (k < FLASH_FRAMES) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 2'd3;
    scroll_en = 1'b1;
    flash_req = 1'b0;
    setTiming(0, V_ACT);
    repeat (4) @(negedge clk);
    checkOutput("reset_timing", 32'({vout.vcount, vout.hcount, vout.vsync, vout.hsync, vout.vblnk, vout.hblnk}), 32'd0);
    checkOutput("reset_rgb", 32'(vout.rgb), 32'd0);
    checkOutput("reset_busy", 32'(flash_busy), 32'd0);

    // Release inside vblank: no frame start, so mode stays solid.
    rst = 1'b0;
    applyStimulus(1, V_ACT, 1'b0);
    applyStimulus(2, V_ACT + 1, 1'b0);
    checkPixel("no_fs_after_reset", 31, 0, COLOR_A);

    // Vertical stripes with scrolling: one frame start gives offset 1, three give offset 3.
    quickFs();
    checkPixel("stripe_off1_h30", 30, 0, COLOR_A);
    checkPixel("stripe_off1_h31", 31, 0, COLOR_B);
    quickFs();
    quickFs();
    checkPixel("stripe_off3_h29", 29, 0, COLOR_B);
    checkOutput("hcount_delay", 32'(vout.hcount), 32'd29);
    checkPixel("stripe_off3_h28", 28, 0, COLOR_A);

    // Solid fill over a complete raster.
    mode      = 2'd0;
    scroll_en = 1'b0;
    quickFs();
    fullFrame();
    checkPixel("solid_after_frame", 40, 20, COLOR_A);

    // Scroll the offset from 3 up to 2047, then across the wrap to 0.
    mode      = 2'd3;
    scroll_en = 1'b1;
    repeat (2044) quickFs();
    checkPixel("wrap_2047_h0", 0, 0, COLOR_B);
    checkPixel("wrap_2047_h32", 32, 0, COLOR_A);
    quickFs();
    checkPixel("wrap_0_h0", 0, 0, COLOR_A);
    checkPixel("wrap_0_h32", 32, 0, COLOR_B);

    // Checkerboard at offset 0.
    scroll_en = 1'b0;
    mode      = 2'd2;
    quickFs();
    checkPixel("checker_0_0", 0, 0, COLOR_A);
    checkPixel("checker_32_0", 32, 0, COLOR_B);
    checkPixel("checker_32_32", 32, 32, COLOR_A);
    checkPixel("checker_0_32", 0, 32, COLOR_B);

    // Flash: busy on the request's own output, colour from the following pixel.
    mode = 2'd0;
    quickFs();
    applyStimulus(5, 5, 1'b1);
    checkOutput("flash_busy_rise", 32'(flash_busy), 32'd1);
    checkOutput("flash_req_pixel_rgb", 32'(vout.rgb), 32'(COLOR_A));
    checkPixel("flash_next_pixel", 6, 5, FLASH_COLOR);
    flashCountdown("flash");

    // Retrigger when three frames remain.
    applyStimulus(5, 5, 1'b1);
    repeat (5) quickFs();
    checkPixel("retrig_cnt3_rgb", 3, 3, FLASH_COLOR);
    applyStimulus(5, 5, 1'b1);
    flashCountdown("retrig");

    // Request on the frame-start cycle with five frames remaining reloads to eight.
    applyStimulus(5, 5, 1'b1);
    repeat (3) quickFs();
    applyStimulus(H_ACT, 0, 1'b0);
    applyStimulus(0, V_ACT, 1'b1);
    flashCountdown("fs_req");

    // Mode change mid-frame waits for the next frame start.
    mode = 2'd1;
    quickFs();
    mode = 2'd2;
    checkPixel("midframe_bands_32_0", 32, 0, COLOR_A);
    checkPixel("midframe_bands_32_32", 32, 32, COLOR_B);
    quickFs();
    checkPixel("after_fs_checker_32_0", 32, 0, COLOR_B);
    checkPixel("after_fs_checker_32_32", 32, 32, COLOR_A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
